// File: rtl/hardmax_stream.sv
// Streaming argmax over one score vector per frame with valid/ready handshakes and length checking.
// Optional runner-up index and margin outputs are enabled by defining HARDMAX_RUNNERUP_EN.
module hardmax_stream #(
  parameter int N_CLASSES  = 10,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 4,
  parameter int SIGNED_CMP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IDX_W-1:0]  m_index,
  output logic [DATA_W-1:0] m_max,
  output logic              m_err
`ifdef HARDMAX_RUNNERUP_EN
  ,
  output logic [IDX_W-1:0]  m_index2,
  output logic [DATA_W:0]   m_margin
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DRAIN} state_t;

  localparam logic [IDX_W:0] NC = (IDX_W + 1)'(N_CLASSES);

  state_t            state;
  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  idxR;
  logic [DATA_W-1:0] maxR;
  logic              sReadyR;
  logic              mValidR;
  logic              mErrR;
  logic              lastSeen;

  logic              beat;
  logic              first;
  logic              take;
  logic              close;
  logic              err;
  logic [IDX_W:0]    cnt1;

  function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
    else                 return a > b;
  endfunction

`ifdef HARDMAX_RUNNERUP_EN
  logic [IDX_W-1:0]  idx2R;
  logic [DATA_W-1:0] max2R;
  logic              has2;

  function automatic logic [DATA_W:0] ext(input logic [DATA_W-1:0] a);
    if (SIGNED_CMP != 0) return {a[DATA_W-1], a};
    else                 return {1'b0, a};
  endfunction

  assign m_index2 = idx2R;
  assign m_margin = ext(maxR) - ext(max2R);
`endif

  // The first beat of a frame (accepted in IDLE) always becomes the max; later beats compare.
  always_comb begin
    beat  = s_valid & sReadyR & ((state == IDLE) | (state == SCAN));
    first = (state == IDLE);
    cnt1  = first ? (IDX_W + 1)'(1) : {1'b0, count} + (IDX_W + 1)'(1);
    take  = first | greater(s_data, maxR);
    close = s_last | (cnt1 == NC);
    err   = s_last ? (cnt1 < NC) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      idxR     <= '0;
      maxR     <= '0;
      sReadyR  <= 1'b0;
      mValidR  <= 1'b0;
      mErrR    <= 1'b0;
      lastSeen <= 1'b0;
`ifdef HARDMAX_RUNNERUP_EN
      idx2R    <= '0;
      max2R    <= '0;
      has2     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, SCAN: begin
          if (!sReadyR) begin
            sReadyR <= 1'b1;
          end else if (beat) begin
            count <= cnt1[IDX_W-1:0];
            if (take) begin
              maxR <= s_data;
              idxR <= first ? '0 : count;
            end
`ifdef HARDMAX_RUNNERUP_EN
            // A displaced max becomes the runner-up; otherwise the first non-winning beat seeds it.
            if (first) begin
              max2R <= s_data;
              idx2R <= '0;
              has2  <= 1'b0;
            end else if (take) begin
              max2R <= maxR;
              idx2R <= idxR;
              has2  <= 1'b1;
            end else if (!has2 || greater(s_data, max2R)) begin
              max2R <= s_data;
              idx2R <= count;
              has2  <= 1'b1;
            end
`endif
            if (close) begin
              state    <= HOLD;
              sReadyR  <= 1'b0;
              mValidR  <= 1'b1;
              mErrR    <= err;
              lastSeen <= s_last;
            end else begin
              state <= SCAN;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            mValidR <= 1'b0;
            sReadyR <= 1'b1;
            state   <= lastSeen ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (s_valid && sReadyR && s_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_ready = sReadyR;
  assign m_valid = mValidR;
  assign m_index = idxR;
  assign m_max   = maxR;
  assign m_err   = mErrR;

endmodule
